// File: rtl/mac_pkg.sv
// Shared types, default widths and the saturating counter helper for the MAC accumulator.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;
  localparam int CNT_W_DEF  = 8;
  localparam int CNT_MAX_W  = 32;

  // Increment that sticks at the all-ones value of the caller's counter width.
  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] value,
                                                   input logic [CNT_MAX_W-1:0] all_ones);
    if (value == all_ones) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Accumulator adder: sign-extends the product, flags signed overflow at ACC_W,
// and clamps to the signed range when MAC_SAT_EN is defined (wraps otherwise).
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] raw;

  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign raw      = acc + prod_ext;
  assign ovf      = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

  always_comb begin
    sum = raw;
`ifdef MAC_SAT_EN
    if (ovf) begin
      // Both operands share a sign on overflow, so acc's sign picks the rail.
      sum = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = raw;
    end
`endif
  end

endmodule

// File: rtl/mac_accumulator.sv
// Streaming signed multiply-accumulate reduction stage with valid/ready handshakes.
// Optional clamping of the running sum is enabled by defining MAC_SAT_EN.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf;
  logic             add_ovf;
  logic             accept;
  logic             last_accept;

  mac_sat_add #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc (acc),
    .prod(in_prod),
    .sum (sum),
    .ovf (add_ovf)
  );

  assign out_valid   = (state == HOLD);
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && in_last;
  assign cnt_inc     = CNT_W'(sat_inc(CNT_MAX_W'(cnt), CNT_MAX_W'(CNT_ONES)));

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: begin
        if (last_accept) begin
          state_next = HOLD;
        end else begin
          state_next = ACCUM;
        end
      end
      HOLD: begin
        // A drain coinciding with a new last term reloads and stays in HOLD.
        if (last_accept) begin
          state_next = HOLD;
        end else if (out_ready) begin
          state_next = ACCUM;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (last_accept) begin
        out_acc   <= sum;
        out_count <= cnt_inc;
        out_ovf   <= ovf | add_ovf;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt_inc;
        ovf <= ovf | add_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator (default widths plus an ACC_W=17 instance).
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_valid17;
  logic        in_ready;
  logic        in_ready17;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_valid17;
  logic        out_ready;
  logic [31:0] out_acc;
  logic [16:0] out_acc17;
  logic [7:0]  out_count;
  logic [7:0]  out_count17;
  logic        out_ovf;
  logic        out_ovf17;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  mac_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid17), .in_ready(in_ready17),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid17),
    .out_ready(out_ready), .out_acc(out_acc17), .out_count(out_count17), .out_ovf(out_ovf17)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int value, input logic last);
    in_valid = 1'b1;
    in_prod  = 16'(value);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    longint exp17;
    rst = 1'b1; in_valid = 1'b0; in_valid17 = 1'b0; in_prod = 16'd0;
    in_last = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_acc", out_acc, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_ready", in_ready, 1);

    // 100, -50, 7 -> 57
    send(100, 1'b0); send(-50, 1'b0);
    check("mid_vec_valid", out_valid, 0);
    send(7, 1'b1);
    check("v1_valid", out_valid, 1);
    check("v1_acc", $signed(out_acc), 57);
    check("v1_count", out_count, 3);
    check("v1_ovf", out_ovf, 0);
    step();
    check("v1_valid_drop", out_valid, 0);

    send(-16256, 1'b1);
    check("single_acc", $signed(out_acc), -16256);
    check("single_count", out_count, 1);
    step();

    // Stalled result with the next vector waiting upstream
    out_ready = 1'b0;
    send(5, 1'b0); send(5, 1'b1);
    check("stall_valid", out_valid, 1);
    check("stall_acc0", $signed(out_acc), 10);
    in_valid = 1'b1; in_prod = 16'd9; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_ready", in_ready, 0);
      step();
      check("stall_acc", $signed(out_acc), 10);
      check("stall_hold", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", in_ready, 1);
    step();
    check("release_drain", out_valid, 0);
    send(11, 1'b1);
    check("after_stall_acc", $signed(out_acc), 20);
    check("after_stall_count", out_count, 2);
    step();

    // Back-to-back vectors {1,2} {3,4}
    send(1, 1'b0);
    check("b2b_ready0", in_ready, 1);
    send(2, 1'b1);
    check("b2b_acc0", $signed(out_acc), 3);
    check("b2b_ready1", in_ready, 1);
    send(3, 1'b0);
    check("b2b_ready2", in_ready, 1);
    send(4, 1'b1);
    check("b2b_valid1", out_valid, 1);
    check("b2b_acc1", $signed(out_acc), 7);
    check("b2b_count1", out_count, 2);
    step();

    // Counter saturation: 300 terms of 1
    for (int i = 0; i < 299; i++) send(1, 1'b0);
    send(1, 1'b1);
    check("sat_cnt_acc", $signed(out_acc), 300);
    check("sat_cnt_count", out_count, 255);
    step();

    // ACC_W=17 overflow, four products of 16384
`ifdef MAC_SAT_EN
    exp17 = 65535;
`else
    exp17 = -65536;
`endif
    for (int i = 0; i < 4; i++) begin
      in_valid17 = 1'b1; in_prod = 16'd16384; in_last = (i == 3);
      step();
    end
    in_valid17 = 1'b0; in_last = 1'b0;
    check("w17_valid", out_valid17, 1);
    check("w17_acc", $signed(out_acc17), exp17);
    check("w17_ovf", out_ovf17, 1);
    check("w17_count", out_count17, 4);
    step();

    // Reset mid-vector discards partial sum
    send(100, 1'b0); send(200, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    send(5, 1'b1);
    check("rst_mid_acc", $signed(out_acc), 5);
    check("rst_mid_count", out_count, 1);
    check("rst_mid_ovf", out_ovf, 0);

    // Reset while HOLD drops the result
    out_ready = 1'b0;
    send(3, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_acc", $signed(out_acc), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
